// File: rtl/cache_pkg.sv
// Shared types and address-geometry helpers for the set-associative data cache.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WB,
        ST_FILL,
        ST_RESP
    } state_t;

    localparam int BYTE_W = 8;

    // Byte-offset bits dropped from the address to form a word address.
    function automatic int off_width(input int data_w);
        return (data_w > BYTE_W) ? $clog2(data_w / BYTE_W) : 0;
    endfunction

    // Index width collapses to zero for a single-set cache.
    function automatic int idx_width(input int sets);
        return (sets > 1) ? $clog2(sets) : 0;
    endfunction

    function automatic int way_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_lru_set.sv
// Age-rank LRU for one set: rank 0 is MRU, rank WAYS-1 is the replacement victim.
module cache_lru_set
    import cache_pkg::*;
#(
    parameter int WAYS = 2,
    localparam int WW = way_width(WAYS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          touch,
    input  logic [WW-1:0] touch_way,
    output logic [WW-1:0] victim
);

    generate
        if (WAYS == 1) begin : g_single
            logic unused_lru;
            assign unused_lru = ^{clk, rst_n, touch, touch_way};
            assign victim     = '0;
        end else begin : g_ranked
            logic [WW-1:0] rank_q [WAYS];
            logic [WW-1:0] rank_d [WAYS];

            // Only ways younger than the touched one age; older ranks keep their order.
            always_comb begin
                for (int i = 0; i < WAYS; i++) begin
                    rank_d[i] = rank_q[i];
                    if (touch) begin
                        if (WW'(i) == touch_way) begin
                            rank_d[i] = '0;
                        end else if (rank_q[i] < rank_q[touch_way]) begin
                            rank_d[i] = rank_q[i] + WW'(1);
                        end
                    end
                end
            end

            always_comb begin
                victim = '0;
                for (int i = 0; i < WAYS; i++) begin
                    if (rank_q[i] == WW'(WAYS - 1)) begin
                        victim = WW'(i);
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < WAYS; i++) begin
                        rank_q[i] <= WW'(i);
                    end
                end else begin
                    for (int i = 0; i < WAYS; i++) begin
                        rank_q[i] <= rank_d[i];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/cache_data_sa.sv
// Write-back, write-allocate set-associative data cache, one word per line.
// Define CACHE_STATS_EN to add saturating hit/miss/write-back counters.
module cache_data_sa
    import cache_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int SETS   = 4,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses,
    output logic [31:0]       stat_writebacks
`endif
);

    localparam int OFF     = off_width(DATA_W);
    localparam int IDX_W   = idx_width(SETS);
    localparam int IDX_S   = (IDX_W > 0) ? IDX_W : 1;
    localparam int WADDR_W = ADDR_W - OFF;
    localparam int TAG_W   = WADDR_W - IDX_W;
    localparam int WW      = way_width(WAYS);

    state_t               state_q, state_d;
    logic                 req_we_q, req_we_d;
    logic [WADDR_W-1:0]   req_waddr_q, req_waddr_d;
    logic [DATA_W-1:0]    req_wdata_q, req_wdata_d;
    logic [WW-1:0]        victim_q, victim_d;

    logic                 req_ready_q, req_ready_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_hit_q, resp_hit_d;
    logic [DATA_W-1:0]    resp_rdata_q, resp_rdata_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;

    logic [WAYS-1:0]      valid_q [SETS];
    logic [WAYS-1:0]      valid_d [SETS];
    logic [WAYS-1:0]      dirty_q [SETS];
    logic [WAYS-1:0]      dirty_d [SETS];
    logic [TAG_W-1:0]     tag_mem [SETS][WAYS];
    logic [DATA_W-1:0]    data_mem [SETS][WAYS];

    logic [IDX_S-1:0]     req_idx;
    logic [TAG_W-1:0]     req_tag;
    logic                 hit, inv_found;
    logic [WW-1:0]        hit_way, inv_way, vsel;
    logic [WW-1:0]        lru_victim [SETS];

    logic                 arr_we, arr_dirty;
    logic [WW-1:0]        arr_way;
    logic [DATA_W-1:0]    arr_data;
    logic                 touch;
    logic [WW-1:0]        touch_way;

    generate
        if (IDX_W > 0) begin : g_idx
            assign req_idx = req_waddr_q[IDX_W-1:0];
        end else begin : g_noidx
            assign req_idx = '0;
        end
        if (OFF > 0) begin : g_lsb
            logic unused_lsb;
            assign unused_lsb = ^req_addr[OFF-1:0];
        end
    endgenerate

    assign req_tag = req_waddr_q[WADDR_W-1 -: TAG_W];

    // Descending scan leaves the lowest-numbered invalid way as the pick.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WW'(w);
            end
        end
        vsel = inv_found ? inv_way : lru_victim[req_idx];
    end

    generate
        for (genvar gi = 0; gi < SETS; gi++) begin : g_lru
            cache_lru_set #(.WAYS(WAYS)) u_lru (
                .clk       (clk),
                .rst_n     (rst_n),
                .touch     (touch && (req_idx == IDX_S'(gi))),
                .touch_way (touch_way),
                .victim    (lru_victim[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        req_we_d     = req_we_q;
        req_waddr_d  = req_waddr_q;
        req_wdata_d  = req_wdata_q;
        victim_d     = victim_q;
        resp_valid_d = 1'b0;
        resp_hit_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        arr_we       = 1'b0;
        arr_dirty    = 1'b0;
        arr_way      = hit_way;
        arr_data     = req_wdata_q;
        touch        = 1'b0;
        touch_way    = hit_way;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_we_d    = req_we;
                    req_waddr_d = req_addr[ADDR_W-1:OFF];
                    req_wdata_d = req_wdata;
                    state_d     = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit) begin
                    touch        = 1'b1;
                    arr_we       = req_we_q;
                    arr_dirty    = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_hit_d   = 1'b1;
                    resp_rdata_d = req_we_q ? '0 : data_mem[req_idx][hit_way];
                    state_d      = ST_RESP;
                end else begin
                    victim_d  = vsel;
                    mem_req_d = 1'b1;
                    if (valid_q[req_idx][vsel] && dirty_q[req_idx][vsel]) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = (ADDR_W'(tag_mem[req_idx][vsel]) << (OFF + IDX_W))
                                    | (ADDR_W'(req_idx) << OFF);
                        mem_wdata_d = data_mem[req_idx][vsel];
                        state_d     = ST_WB;
                    end else begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = ADDR_W'(req_waddr_q) << OFF;
                        state_d    = ST_FILL;
                    end
                end
            end
            ST_WB: begin
                if (mem_ack) begin
                    mem_we_d   = 1'b0;
                    mem_addr_d = ADDR_W'(req_waddr_q) << OFF;
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mem_ack) begin
                    arr_we       = 1'b1;
                    arr_way      = victim_q;
                    arr_dirty    = req_we_q;
                    arr_data     = req_we_q ? req_wdata_q : mem_rdata;
                    touch        = 1'b1;
                    touch_way    = victim_q;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = req_we_q ? '0 : mem_rdata;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);

        valid_d = valid_q;
        dirty_d = dirty_q;
        if (arr_we) begin
            valid_d[req_idx][arr_way] = 1'b1;
            dirty_d[req_idx][arr_way] = arr_dirty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_we_q     <= 1'b0;
            req_waddr_q  <= '0;
            req_wdata_q  <= '0;
            victim_q     <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            state_q      <= state_d;
            req_we_q     <= req_we_d;
            req_waddr_q  <= req_waddr_d;
            req_wdata_q  <= req_wdata_d;
            victim_q     <= victim_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_rdata_q <= resp_rdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= valid_d[s];
                dirty_q[s] <= dirty_d[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            tag_mem[req_idx][arr_way]  <= req_tag;
            data_mem[req_idx][arr_way] <= arr_data;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

`ifdef CACHE_STATS_EN
    logic [31:0] hits_q, hits_d;
    logic [31:0] misses_q, misses_d;
    logic [31:0] wbs_q, wbs_d;

    always_comb begin
        hits_d   = hits_q;
        misses_d = misses_q;
        wbs_d    = wbs_q;
        if (state_q == ST_LOOKUP) begin
            if (hit) begin
                if (hits_q != 32'hFFFF_FFFF) hits_d = hits_q + 32'd1;
            end else begin
                if (misses_q != 32'hFFFF_FFFF) misses_d = misses_q + 32'd1;
                if ((state_d == ST_WB) && (wbs_q != 32'hFFFF_FFFF)) wbs_d = wbs_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q   <= '0;
            misses_q <= '0;
            wbs_q    <= '0;
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
            wbs_q    <= wbs_d;
        end
    end

    assign stat_hits       = hits_q;
    assign stat_misses     = misses_q;
    assign stat_writebacks = wbs_q;
`endif

endmodule

// File: doc/cache_data_sa.md
Name: cache_data_sa

Overview:
- Parametrised set-associative L1/L2 data cache, write-back and write-allocate.
- Successor to the flat fully-associative data caches: adds configurable sets/ways, LRU replacement, dirty tracking, victim write-back, and a valid/ready handshake on both sides.
- Sits between the core load/store path (or an upper cache level) and the next cache level or main memory.
- Several instances can be chained: the lower-side port of one matches the core-side port of the next.

Parameters:
- ADDR_W, 64, byte-address width.
- DATA_W, 64, word width; one word per line.
- SETS, 4, number of sets; power of two, >=1.
- WAYS, 2, associativity; legal values 1, 2, 4.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  cache accepts a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address; low log2(DATA_W/8) bits ignored.
- req_wdata  in  DATA_W  store data.
- resp_valid  out  1  one-cycle pulse: load data valid or store complete.
- resp_rdata  out  DATA_W  load data; 0 for stores.
- resp_hit  out  1  qualifies resp_valid: 1 if the request hit.
- mem_req  out  1  lower-level request; held until mem_ack.
- mem_we  out  1  1 = write-back, 0 = fill read.
- mem_addr  out  ADDR_W  word-aligned lower-level address.
- mem_wdata  out  DATA_W  victim data during write-back.
- mem_ack  in  1  one-cycle completion from the lower level.
- mem_rdata  in  DATA_W  fill data, valid with mem_ack when mem_we = 0.

Behaviour:
- Address split:
  - OFF = log2(DATA_W/8).
  - index = addr[OFF +: log2(SETS)]; SETS = 1 gives index width 0.
  - tag = remaining upper bits.
- Per line state: valid, dirty, tag, data.
- Per set state: LRU state, as an age rank of log2(WAYS) bits per way. WAYS = 1 needs no LRU state.
- Request capture: req_valid & req_ready latches we/addr/wdata. Tag compare on the latched request occurs in LOOKUP, the following cycle.
- FSM states: IDLE, LOOKUP, WB, FILL, RESP.
  - IDLE -> LOOKUP on an accepted request.
  - LOOKUP, hit:
    - Load returns the line data.
    - Store writes the data and sets dirty.
    - Accessed way becomes MRU.
    - resp_valid = 1, resp_hit = 1 in the next cycle; then IDLE.
    - Hit latency = 2 cycles from acceptance to resp_valid.
  - LOOKUP, miss: victim = first invalid way (lowest index), else the LRU way.
    - Victim valid & dirty -> WB.
    - Otherwise -> FILL.
  - WB:
    - mem_req = 1, mem_we = 1, mem_addr = {victim tag, index, OFF zeros}, mem_wdata = victim data.
    - On mem_ack -> FILL.
  - FILL:
    - mem_req = 1, mem_we = 0, mem_addr = request word address.
    - On mem_ack, victim way <= mem_rdata, valid = 1, tag updated, dirty = 0.
    - If the request is a store, store data overwrites the line in the same edge and dirty = 1.
    - Way becomes MRU; -> RESP.
  - RESP:
    - resp_valid = 1, resp_hit = 0.
    - resp_rdata = fill data for a load, 0 for a store.
    - -> IDLE.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are stable while waiting.
  - mem_ack outside WB/FILL is ignored.
  - The lower level may take arbitrarily many cycles.
- Outputs are registered.
- Reset values:
  - req_ready = 1 (IDLE).
  - resp_valid, resp_hit, mem_req and mem_we = 0.
  - resp_rdata, mem_addr and mem_wdata = 0.
  - All valid/dirty bits = 0; LRU ranks = way index.
  - Tag/data arrays need no reset.
- Reset mid-operation: an in-flight request is discarded, mem_req drops immediately, and dirty data is lost (a documented limitation).
- Back-to-back: no request is accepted in the RESP cycle. The next acceptance is possible in the following IDLE cycle.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined:
  - Adds outputs stat_hits, stat_misses and stat_writebacks, 32 bits each.
  - Counts increment on a LOOKUP hit, a LOOKUP miss, and entry to WB respectively.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package cache_pkg:
  - FSM state enum.
  - Function clog2-safe index width (0 when SETS = 1).
  - Localparams for the OFF computation.
- Sub-module cache_lru_set:
  - Per-set age-rank update: on touch of way w, w becomes rank 0 and ways younger than w age by 1.
  - Victim select: highest rank.
  - Instantiated once per set.

Test Plan:
1. Cold load 0x100 (SETS = 4, WAYS = 2) -> FILL read at mem_addr 0x100; mem_rdata 0xDEAD returned with resp_hit = 0. A repeat load returns 0xDEAD with resp_hit = 1 and 2-cycle latency, with no mem_req.
2. Store 0x55 to 0x100 after the fill, then loads mapping to the same set (0x120, then 0x140) -> 0x120 fills the second way. 0x140 evicts 0x100 (LRU) via WB with mem_addr 0x100 and mem_wdata 0x55, then fills 0x140.
3. Store miss to clean set (0x208) -> FILL read of 0x208 only, then line dirty with store data. A later eviction writes back the store data, not the fill data.
4. mem_ack delayed 10 cycles in FILL -> mem_req and mem_addr stable throughout; req_ready = 0; a spurious mem_ack in IDLE is ignored.
5. Assert rst_n low during WB -> mem_req is 0 the same cycle. After release, req_ready = 1 and a load of the old address misses.
6. With CACHE_STATS_EN: the sequence of test 2 yields stat_hits = 1, stat_misses = 3, stat_writebacks = 1.
